// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
//
// Host-side UART debug/loader initiator. Receives 8N1 command frames on RXD,
// performs one 32-bit read or write on the system bus as bus master, and sends
// the result back on TXD. All logic runs on CLK; RES is synchronous active-high.
//
// Command protocol (bytes on RXD):
//   'W' A3 A2 A1 A0 D3 D2 D1 D0 -> bus write, reply 0x06
//   'R' A3 A2 A1 A0             -> bus read,  reply 4 data bytes MSB first
//   '?'                         -> reply 0x42
//   anything else               -> reply 0x15
//
// Ports:
//   CLK    in   1   clock
//   RES    in   1   synchronous active-high reset
//   RXD    in   1   serial input, asynchronous to CLK
//   TXD    out  1   serial output, idle high
//   RD     out  1   bus read strobe
//   WR     out  1   bus write strobe
//   BE     out  4   byte enables, 4'hF while a strobe is active, else 0
//   ADDR   out 32   bus address
//   DATAO  out 32   bus write data
//   DATAI  in  32   bus read data
//   HLT    in   1   bus wait: 1 extends the current access
//   BUSY   out  1   1 while a command is in progress
//
// Parameters:
//   BAUD     bit period minus one, in CLK cycles
//   TIMEOUT  inter-byte idle limit (CLK cycles) while collecting a command
// -----------------------------------------------------------------------------
module uart_bus_bridge #(
  parameter logic [15:0] BAUD    = 16'd867,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RXD,
  output logic        TXD,
  output logic        RD,
  output logic        WR,
  output logic [3:0]  BE,
  output logic [31:0] ADDR,
  output logic [31:0] DATAO,
  input  logic [31:0] DATAI,
  input  logic        HLT,
  output logic        BUSY
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [3:0] {
    S_CMD, S_A3, S_A2, S_A1, S_A0, S_D3, S_D2, S_D1, S_D0, S_BUS, S_TX
  } cmd_state_e;

  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_Q    = 8'h3F;
  localparam logic [7:0] RSP_ID  = 8'h42;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_ACK = 8'h06;

  // Mid-bit offset from the detected start edge; the counter reaches zero on
  // the (BAUD+1)/2-th cycle, so it is loaded with one less.
  localparam logic [16:0] HALF_BIT = ({1'b0, BAUD} + 17'd1) >> 1;
  localparam logic [15:0] HALF_M1  = (HALF_BIT == 17'd0) ? 16'd0 : 16'(HALF_BIT - 17'd1);
  localparam logic [23:0] TO_LAST  = (TIMEOUT == 24'd0) ? 24'd0 : TIMEOUT - 24'd1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]  rx_sync_q,  rx_sync_d;
  logic        rx_last_q,  rx_last_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]  rx_bit_q,   rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  cmd_state_e  state_q,    state_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] datao_q,    datao_d;
  logic [23:0] to_cnt_q,   to_cnt_d;

  logic        txd_q,      txd_d;
  logic [15:0] tx_cnt_q,   tx_cnt_d;
  logic [3:0]  tx_bit_q,   tx_bit_d;
  logic [8:0]  tx_frame_q, tx_frame_d;   // remaining data bits plus stop bit
  logic [1:0]  tx_left_q,  tx_left_d;    // reply bytes still queued after this one
  logic [23:0] reply_q,    reply_d;      // queued reply bytes, next one in [23:16]

  logic        rx_s;
  logic        rx_fall;
  logic        rx_byte_stb;
  logic        rx_frame_err;
  logic        in_hdr;
  logic        tx_enter;
  logic        tx_done;
  logic [7:0]  tx_first;

  assign rx_s    = rx_sync_q[2];
  assign rx_fall = rx_last_q & ~rx_s;
  assign in_hdr  = (state_q == S_A3) || (state_q == S_A2) || (state_q == S_A1) ||
                   (state_q == S_A0) || (state_q == S_D3) || (state_q == S_D2) ||
                   (state_q == S_D1) || (state_q == S_D0);

  // ---------------------------------------------------------------------------
  // RX: synchroniser, start detection, mid-bit sampling
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rx_sync_d    = {rx_sync_q[1:0], RXD};
    rx_last_d    = rx_s;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_stb  = 1'b0;
    rx_frame_err = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s) begin
          rx_state_d = RX_IDLE;            // glitch, not a real start bit
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = BAUD;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};   // LSB arrives first
          rx_cnt_d   = BAUD;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_state_d = RX_IDLE;
          if (rx_s) rx_byte_stb  = 1'b1;
          else      rx_frame_err = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD: begin
        if (rx_byte_stb)
          state_d = (rx_shift_q == CH_W || rx_shift_q == CH_R) ? S_A3 : S_TX;
      end
      S_A3, S_A2, S_A1, S_A0, S_D3, S_D2, S_D1, S_D0: begin
        if (rx_frame_err) begin
          state_d = S_CMD;
        end else if (rx_byte_stb) begin
          case (state_q)
            S_A3:    state_d = S_A2;
            S_A2:    state_d = S_A1;
            S_A1:    state_d = S_A0;
            S_A0:    state_d = is_write_q ? S_D3 : S_BUS;
            S_D3:    state_d = S_D2;
            S_D2:    state_d = S_D1;
            S_D1:    state_d = S_D0;
            default: state_d = S_BUS;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_CMD;                 // stale partial command dropped
        end
      end
      S_BUS:   if (!HLT)   state_d = S_TX;
      S_TX:    if (tx_done) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    RD   = (state_q == S_BUS) && !is_write_q;
    WR   = (state_q == S_BUS) &&  is_write_q;
    BE   = (state_q == S_BUS) ? 4'hF : 4'h0;
    BUSY = (state_q != S_CMD);
  end

  assign ADDR  = addr_q;
  assign DATAO = datao_q;
  assign TXD   = txd_q;

  // ---------------------------------------------------------------------------
  // Command datapath: opcode, address, write data, inter-byte timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    is_write_d = is_write_q;
    addr_d     = addr_q;
    datao_d    = datao_q;
    to_cnt_d   = 24'd0;

    if (rx_byte_stb) begin
      case (state_q)
        S_CMD:   is_write_d = (rx_shift_q == CH_W);
        S_A3:    addr_d[31:24]  = rx_shift_q;
        S_A2:    addr_d[23:16]  = rx_shift_q;
        S_A1:    addr_d[15:8]   = rx_shift_q;
        S_A0:    addr_d[7:0]    = rx_shift_q;
        S_D3:    datao_d[31:24] = rx_shift_q;
        S_D2:    datao_d[23:16] = rx_shift_q;
        S_D1:    datao_d[15:8]  = rx_shift_q;
        S_D0:    datao_d[7:0]   = rx_shift_q;
        default: ;
      endcase
    end

    if (in_hdr && !rx_byte_stb) to_cnt_d = to_cnt_q + 24'd1;
  end

  // ---------------------------------------------------------------------------
  // TX: reply serialiser, bytes back-to-back
  // ---------------------------------------------------------------------------
  assign tx_enter = (state_d == S_TX) && (state_q != S_TX);
  assign tx_done  = (state_q == S_TX) && (tx_cnt_q == 16'd0) &&
                    (tx_bit_q == 4'd9) && (tx_left_q == 2'd0);

  always_comb begin
    txd_d      = txd_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    tx_left_d  = tx_left_q;
    reply_d    = reply_q;

    // The read reply takes DATAI on the completing edge itself.
    if (state_q == S_BUS) tx_first = is_write_q ? RSP_ACK : DATAI[31:24];
    else                  tx_first = (rx_shift_q == CH_Q) ? RSP_ID : RSP_NAK;

    if (tx_enter) begin
      txd_d      = 1'b0;
      tx_frame_d = {1'b1, tx_first};
      tx_bit_d   = 4'd0;
      tx_cnt_d   = BAUD;
      tx_left_d  = (state_q == S_BUS && !is_write_q) ? 2'd3 : 2'd0;
      reply_d    = DATAI[23:0];
    end else if (state_q == S_TX) begin
      // tx_bit_q names the bit on the line: 0 start, 1..8 data, 9 stop.
      if (tx_cnt_q != 16'd0) begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end else if (tx_bit_q != 4'd9) begin
        txd_d      = tx_frame_q[0];
        tx_frame_d = {1'b1, tx_frame_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_cnt_d   = BAUD;
      end else if (tx_left_q != 2'd0) begin
        txd_d      = 1'b0;
        tx_frame_d = {1'b1, reply_q[23:16]};
        reply_d    = {reply_q[15:0], 8'h00};
        tx_left_d  = tx_left_q - 2'd1;
        tx_bit_d   = 4'd0;
        tx_cnt_d   = BAUD;
      end
    end else begin
      txd_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the values from before this edge regardless of order.
    if (RES) begin
      // The synchroniser resets to the idle line level so that leaving reset
      // never looks like a start edge.
      rx_sync_q  <= 3'b111;
      rx_last_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      state_q    <= S_CMD;
      is_write_q <= 1'b0;
      addr_q     <= 32'd0;
      datao_q    <= 32'd0;
      to_cnt_q   <= 24'd0;
      txd_q      <= 1'b1;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 4'd0;
      tx_frame_q <= 9'h1FF;
      tx_left_q  <= 2'd0;
      reply_q    <= 24'd0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_last_q  <= rx_last_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      datao_q    <= datao_d;
      to_cnt_q   <= to_cnt_d;
      txd_q      <= txd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      tx_left_q  <= tx_left_d;
      reply_q    <= reply_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_bridge
//
// Drives commands into uart_bus_bridge through a serial line model, decodes
// TXD back into bytes, watches the bus strobes, and compares against expected
// values from a directed table, hand sequences, and a command-level model
// used for randomized commands.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

  localparam int BIT = 16;   // BAUD = 15

  logic        CLK = 1'b0;
  logic        RES;
  logic        RXD;
  logic        TXD;
  logic        RD;
  logic        WR;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic [31:0] DATAO;
  logic [31:0] DATAI;
  logic        HLT;
  logic        BUSY;

  uart_bus_bridge #(
    .BAUD    (16'd15),
    .TIMEOUT (24'd200)
  ) dut (
    .CLK   (CLK),
    .RES   (RES),
    .RXD   (RXD),
    .TXD   (TXD),
    .RD    (RD),
    .WR    (WR),
    .BE    (BE),
    .ADDR  (ADDR),
    .DATAO (DATAO),
    .DATAI (DATAI),
    .HLT   (HLT),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus monitor and wait-state generator (written only by this process)
  // ---------------------------------------------------------------------------
  int          rd_tot = 0, wr_tot = 0, be_err = 0, txd_low_tot = 0;
  int          busy_fall_cyc = 0;
  int          strobe_base = 0;   // written by the stimulus process only
  int          hlt_n = 0;         // written by the stimulus process only
  logic [31:0] st_addr = '0, st_data = '0;
  logic        busy_prev = 1'b0;

  initial begin
    HLT = 1'b0;
    forever begin
      @(negedge CLK);
      if (RD === 1'b1) rd_tot++;
      if (WR === 1'b1) wr_tot++;
      if ((RD === 1'b1 || WR === 1'b1) ? (BE !== 4'hF) : (BE !== 4'h0)) be_err++;
      if (RD === 1'b1 || WR === 1'b1) begin
        st_addr = ADDR;
        st_data = DATAO;
      end
      if (TXD !== 1'b1) txd_low_tot++;
      if (busy_prev && BUSY === 1'b0) busy_fall_cyc = cyc;
      busy_prev = (BUSY === 1'b1);
      // Hold HLT for the first hlt_n strobe cycles of the current access.
      HLT = ((rd_tot + wr_tot - strobe_base) <= hlt_n);
    end
  end

  // ---------------------------------------------------------------------------
  // TXD decoder: samples each bit near its middle
  // ---------------------------------------------------------------------------
  logic [7:0] tx_bytes[$];
  int         tx_start[$];
  int         tx_stop_err = 0;
  logic [7:0] dec_b;
  int         dec_st;

  initial begin
    forever begin
      @(negedge CLK);
      if (TXD === 1'b0) begin
        dec_st = cyc;
        repeat (BIT/2 - 1) @(negedge CLK);
        if (TXD === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge CLK);
            dec_b[i] = TXD;
          end
          repeat (BIT) @(negedge CLK);
          if (TXD !== 1'b1) tx_stop_err++;
          tx_bytes.push_back(dec_b);
          tx_start.push_back(dec_st);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (BIT) @(negedge CLK);
    end
    RXD = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("busy_bounded", {31'd0, BUSY}, 32'd0);
  endtask

  typedef struct {
    logic [71:0] cmd;       // command bytes, first byte in [71:64]
    int          n;
    logic [31:0] datai;
    int          hlt;
    int          exp_rd;    // expected RD-high cycles
    int          exp_wr;    // expected WR-high cycles
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_nrep;
    logic [31:0] exp_rep;   // reply bytes, first byte in [31:24]
    int          exp_len;   // expected TX-start to BUSY-fall cycles, 0 = skip
  } vec_t;

  function automatic vec_t mk(input logic [71:0] cmd, input int n, input logic [31:0] datai,
                              input int hlt, input int rd, input int wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int nrep, input logic [31:0] rep, input int len);
    vec_t v;
    v.cmd = cmd;   v.n = n;          v.datai = datai;  v.hlt = hlt;
    v.exp_rd = rd; v.exp_wr = wr;    v.exp_addr = addr; v.exp_data = data;
    v.exp_nrep = nrep; v.exp_rep = rep; v.exp_len = len;
    return v;
  endfunction

  // Command-level reference: what the host should observe for one command.
  function automatic vec_t model(input logic [71:0] cmd, input int n,
                                 input logic [31:0] datai, input int hlt);
    logic [7:0] op;
    op = cmd[71:64];
    if (op == 8'h57 && n == 9)
      return mk(cmd, n, datai, hlt, 0, hlt + 1, cmd[63:32], cmd[31:0], 1, 32'h06000000, 0);
    else if (op == 8'h52 && n == 5)
      return mk(cmd, n, datai, hlt, hlt + 1, 0, cmd[63:32], 32'h0, 4, datai, 0);
    else if (op == 8'h3F)
      return mk(cmd, n, datai, hlt, 0, 0, 32'h0, 32'h0, 1, 32'h42000000, 0);
    else
      return mk(cmd, n, datai, hlt, 0, 0, 32'h0, 32'h0, 1, 32'h15000000, 0);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int rd0, wr0, be0, q0, nrep;
    DATAI       = v.datai;
    hlt_n       = v.hlt;
    rd0         = rd_tot;
    wr0         = wr_tot;
    be0         = be_err;
    q0          = tx_bytes.size();
    strobe_base = rd0 + wr0;
    for (int i = 0; i < v.n; i++) send_byte(v.cmd[71-8*i -: 8], 1'b1);
    wait_idle();
    repeat (4) @(negedge CLK);
    check({tag, ".rd_cycles"}, rd_tot - rd0, v.exp_rd);
    check({tag, ".wr_cycles"}, wr_tot - wr0, v.exp_wr);
    check({tag, ".be"}, be_err - be0, 0);
    if (v.exp_rd + v.exp_wr > 0) check({tag, ".addr"}, st_addr, v.exp_addr);
    if (v.exp_wr > 0)            check({tag, ".datao"}, st_data, v.exp_data);
    nrep = tx_bytes.size() - q0;
    check({tag, ".nreply"}, nrep, v.exp_nrep);
    for (int i = 0; i < v.exp_nrep; i++)
      if (i < nrep) check($sformatf("%s.reply%0d", tag, i), {24'd0, tx_bytes[q0+i]},
                          {24'd0, v.exp_rep[31-8*i -: 8]});
    if (v.exp_nrep == 4 && nrep >= 4)
      check({tag, ".back_to_back"}, tx_start[q0+3] - tx_start[q0], 3 * 10 * BIT);
    if (v.exp_len > 0 && nrep > 0)
      check({tag, ".frame_len"}, busy_fall_cyc - tx_start[q0], v.exp_len);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t tbl[5];

  initial begin
    int rd0, wr0, q0, low0, n;
    logic [7:0]  op;
    logic [31:0] ra, rdat, rdi;
    vec_t        v;

    tbl[0] = mk({8'h57, 32'h00000100, 32'hDEADBEEF}, 9, 32'h0, 0,
                0, 1, 32'h00000100, 32'hDEADBEEF, 1, 32'h06000000, 10 * BIT);
    tbl[1] = mk({8'h52, 32'h00000200, 32'h0}, 5, 32'h12345678, 5,
                6, 0, 32'h00000200, 32'h0, 4, 32'h12345678, 0);
    tbl[2] = mk({8'h41, 64'h0}, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h15000000, 0);
    tbl[3] = mk({8'h3F, 64'h0}, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h42000000, 0);
    tbl[4] = mk({8'h57, 32'h80000000, 32'h00000001}, 9, 32'h0, 2,
                0, 3, 32'h80000000, 32'h00000001, 1, 32'h06000000, 0);

    RES   = 1'b1;
    RXD   = 1'b1;
    DATAI = 32'h0;
    repeat (3) @(negedge CLK);
    check("reset.txd",   {31'd0, TXD},  32'd1);
    check("reset.rd",    {31'd0, RD},   32'd0);
    check("reset.wr",    {31'd0, WR},   32'd0);
    check("reset.be",    {28'd0, BE},   32'd0);
    check("reset.addr",  ADDR,          32'd0);
    check("reset.datao", DATAO,         32'd0);
    check("reset.busy",  {31'd0, BUSY}, 32'd0);
    RES = 1'b0;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Partial command left idle past the inter-byte timeout.
    rd0 = rd_tot; wr0 = wr_tot; q0 = tx_bytes.size(); low0 = txd_low_tot;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (150) @(negedge CLK);
    check("timeout.busy_before", {31'd0, BUSY}, 32'd1);
    repeat (150) @(negedge CLK);
    check("timeout.busy_after", {31'd0, BUSY}, 32'd0);
    check("timeout.strobes", (rd_tot - rd0) + (wr_tot - wr0), 0);
    check("timeout.txd_quiet", txd_low_tot - low0, 0);
    check("timeout.no_reply", tx_bytes.size() - q0, 0);
    run_vec(model({8'h52, 32'h00000004, 32'h0}, 5, 32'hCAFEF00D, 0), "after_timeout");

    // Framing error in the address phase.
    rd0 = rd_tot; wr0 = wr_tot; q0 = tx_bytes.size();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (2 * BIT) @(negedge CLK);
    check("frame_err.busy", {31'd0, BUSY}, 32'd0);
    check("frame_err.strobes", (rd_tot - rd0) + (wr_tot - wr0), 0);
    check("frame_err.no_reply", tx_bytes.size() - q0, 0);
    run_vec(model({8'h57, 32'h00001000, 32'h0BADC0DE}, 9, 32'h0, 1), "after_frame_err");

    // Reset during a held read access.
    hlt_n = 1000000;
    strobe_base = rd_tot + wr_tot;
    q0 = tx_bytes.size();
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    n = 0;
    while (RD !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("rst_bus.rd_seen", {31'd0, RD}, 32'd1);
    repeat (3) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    check("rst_bus.rd",   {31'd0, RD},   32'd0);
    check("rst_bus.txd",  {31'd0, TXD},  32'd1);
    check("rst_bus.busy", {31'd0, BUSY}, 32'd0);
    check("rst_bus.be",   {28'd0, BE},   32'd0);
    RES = 1'b0;
    hlt_n = 0;
    rd0 = rd_tot; low0 = txd_low_tot;
    strobe_base = rd_tot + wr_tot;
    repeat (400) @(negedge CLK);
    check("rst_bus.no_more_rd", rd_tot - rd0, 0);
    check("rst_bus.txd_quiet", txd_low_tot - low0, 0);
    check("rst_bus.no_reply", tx_bytes.size() - q0, 0);

    // Randomized commands against the command-level model.
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rdat = $urandom;
      rdi  = $urandom;
      case ($urandom_range(0, 3))
        0: v = model({8'h57, ra, rdat}, 9, rdi, $urandom_range(0, 4));
        1: v = model({8'h52, ra, 32'h0}, 5, rdi, $urandom_range(0, 4));
        2: v = model({8'h3F, 64'h0}, 1, rdi, 0);
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52 || op == 8'h3F) op = 8'($urandom);
          v = model({op, 64'h0}, 1, rdi, 0);
        end
      endcase
      run_vec(v, $sformatf("rand%0d", i));
    end

    check("tx_stop_bits", tx_stop_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, want completion", tests);
    $fatal(1);
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Serial debug/loader initiator: the host end of the UART link, driving the core bus instead of sitting on it as a peripheral.
- Receives framed commands on RXD (8N1), executes one 32-bit bus read or write as bus master, and returns the result on TXD.
- Sits between an external host and the system bus, alongside the core, for memory load/peek/poke without firmware.

Parameters:
- BAUD, 16'd867, bit period minus 1, in CLK cycles (bit = BAUD+1 cycles).
- TIMEOUT, 24'd1000000, inter-byte idle limit in CLK cycles; an expired partial command is dropped silently.

Ports:
- CLK  in  1  clock.
- RES  in  1  reset, synchronous, active-high.
- RXD  in  1  serial input, async to CLK.
- TXD  out  1  serial output, idle high.
- RD  out  1  bus read strobe.
- WR  out  1  bus write strobe.
- BE  out  4  byte enables, always 4'b1111 when a strobe is active, else 0.
- ADDR  out  32  bus address.
- DATAO  out  32  write data.
- DATAI  in  32  read data.
- HLT  in  1  bus wait: 1 = extend current access.
- BUSY  out  1  1 while any command is in progress (RX of byte 2 onward through last TX stop bit).

Behaviour:
- One clock, CLK; RES is synchronous active-high; all state is updated on the CLK rising edge.
- Reset values: TXD=1, RD=0, WR=0, BE=0, ADDR=0, DATAO=0, BUSY=0; RX and TX FSMs idle; timeout counter cleared.
- RES mid-operation aborts everything immediately: no strobe in the following cycle, TXD=1 next cycle, partial byte discarded.
- RX synchroniser:
  - RXD passes through a 3-flop synchroniser.
  - A start is a 1->0 transition on the synchronised output.
  - Sampling is at the mid-bit point: (BAUD+1)/2 cycles after the start edge, then every BAUD+1 cycles.
  - If the start bit samples 1, abort and return to idle.
  - If the stop bit samples 0, it is a framing error: discard the byte; the command FSM returns to CMD.
  - A completed byte produces a one-cycle internal strobe.
- Command FSM states: CMD, A3, A2, A1, A0, D3, D2, D1, D0, BUS, TX.
  - CMD:
    - 0x57 'W' -> A3.
    - 0x52 'R' -> A3.
    - 0x3F '?' -> TX with a single reply byte 0x42.
    - Any other byte -> TX with reply 0x15 (NAK).
  - A3..A0 load ADDR[31:24] down to ADDR[7:0] (MSB first). After A0: 'W' -> D3, 'R' -> BUS.
  - D3..D0 load DATAO, MSB first. After D0 -> BUS.
  - BUS:
    - RD or WR is asserted in the first BUS cycle together with ADDR and BE.
    - Strobes stay asserted while HLT=1.
    - The access completes on the first edge with HLT=0. RD data is captured from DATAI on that edge.
    - Strobes deassert the following cycle. Minimum strobe width is 1 cycle.
  - Reply after BUS -> TX:
    - 'W' replies 1 byte, 0x06 (ACK).
    - 'R' replies 4 bytes, captured data MSB first.
  - TX -> CMD after the stop bit of the last reply byte.
  - Bytes arriving during BUS/TX are ignored (half-duplex protocol).
- TX framing per byte: start 0, bits LSB first, stop 1, each bit exactly BAUD+1 cycles. Consecutive reply bytes are back-to-back with no extra idle.
- Timeout:
  - The counter runs in A3..D0 and resets on every received byte.
  - Reaching TIMEOUT returns the FSM to CMD with no reply and no bus access.
  - Timeout is not checked in CMD, BUS or TX.
- BUSY: 1 from the exit of CMD (including '?' and NAK) until the return to CMD.
- Byte counters are modular; a new command byte is accepted the cycle after returning to CMD.

Test Plan:
- BAUD=15. Send 57 00 00 01 00 DE AD BE EF with HLT=0 -> exactly one WR cycle, ADDR=0x00000100, DATAO=0xDEADBEEF, BE=4'hF; TXD then emits 0x06, 160 cycles for the frame.
- Send 52 00 00 02 00 with DATAI=0x12345678 and HLT held 1 for 5 cycles -> RD high for 6 cycles; TXD emits 12 34 56 78 back-to-back.
- Send 0x41 -> TXD emits 0x15; RD=WR=0 throughout. Send '?' -> TXD emits 0x42.
- Send 57 00 00, then idle with TIMEOUT=200 -> no strobe, no TXD activity, BUSY falls; a following 52 00 00 00 04 executes a normal read.
- Send a byte with stop bit forced 0 mid-address -> byte dropped, FSM back in CMD; a next valid command executes correctly.
- Assert RES during BUS with HLT=1 -> RD=0 next cycle, TXD=1, BUSY=0; no reply is transmitted.
